// File: rtl/cache_pkg.sv
// Shared cache geometry constants and fill-FSM state encoding. The caches
// use the same block constants for their index/tag split.
package cache_pkg;

  localparam int          BLOCK_BYTES     = 16;
  localparam int          WORDS_PER_BLOCK = 8;
  localparam logic [15:0] OFFSET_MASK     = 16'h000F;

  // Fill FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Byte offset of a 16-bit word inside the block. It is four bits wide,
  // so it never carries into the block base.
  function automatic logic [3:0] word_offset(input logic [2:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Cache/memory side signals of the miss fill controller.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] cache_wr_addr;
  logic [DATA_W-1:0] cache_wr_data;

  // Controller view.
  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_en, memory_address, write_data_array,
           write_tag_array, cache_wr_addr, cache_wr_data
  );

  // Cache and memory view.
  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_en, memory_address, write_data_array,
           write_tag_array, cache_wr_addr, cache_wr_data
  );

endinterface

// File: rtl/fill_counter.sv
// 4-bit word counter with synchronous clear and enable. It stops at LIMIT,
// so a full block can be tracked without wrapping.
module fill_counter
  import cache_pkg::*;
#(
  parameter logic [3:0] LIMIT = 4'(WORDS_PER_BLOCK)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt
);

  // Count enabled events and hold once the limit is reached.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment, so every flop
    // samples values from before the edge no matter how blocks are ordered.
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss fill controller. On a miss it fetches the aligned 16-byte block from
// main memory one word at a time and writes each returned word into the
// cache data array. The tag array is written together with the last word,
// and the pipeline stall is released after that write.
module cache_fill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.master bus
);

  import cache_pkg::*;

  // The parameters only restate the shared block geometry. The controller
  // counts returned valids rather than cycles, so any positive latency works.
  if ((WORDS_PER_BLOCK != cache_pkg::WORDS_PER_BLOCK) ||
      (cache_pkg::BLOCK_BYTES != 2 * WORDS_PER_BLOCK) ||
      (MEM_LATENCY < 1) || (ADDR_W < 5)) begin : g_param_check
    $error("cache_fill_ctrl: parameters disagree with cache_pkg geometry");
  end

  logic [0:0]        state;
  logic [ADDR_W-1:0] base;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;
  logic              capt_valid;
  logic [15:0]       capt_data;

  logic in_fill;
  logic accept;
  logic req_en;
  logic wr_en;
  logic last_wr;

  assign in_fill = (state == ST_FILL);
  assign accept  = (state == ST_IDLE) && bus.miss_detected;
  assign req_en  = in_fill && (issue_cnt < 4'(WORDS_PER_BLOCK));
  assign wr_en   = in_fill && capt_valid;
  assign last_wr = wr_en && (recv_cnt == 4'(WORDS_PER_BLOCK - 1));

  // Requests issued to memory: one per cycle until the block is requested.
  fill_counter #(.LIMIT(4'(WORDS_PER_BLOCK))) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (req_en),
    .cnt (issue_cnt)
  );

  // Words written into the cache: one per captured return.
  fill_counter #(.LIMIT(4'(WORDS_PER_BLOCK))) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (wr_en),
    .cnt (recv_cnt)
  );

  // Fill FSM: accept a miss in IDLE and return after the tag write.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it wins over every other update on the same
    // edge, which also discards a fill that is still in flight.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.miss_detected) state <= ST_FILL;
        ST_FILL: if (last_wr)           state <= ST_IDLE;
        default:                        state <= ST_IDLE;
      endcase
    end
  end

  // Block base address, aligned to 16 bytes when the miss is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else if (accept) begin
      base <= bus.miss_address & ~ADDR_W'(OFFSET_MASK);
    end
  end

  // Capture each returned word; it is written to the cache on the next cycle.
  // Returns outside a fill, or alongside the final write, are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      capt_valid <= 1'b0;
      capt_data  <= '0;
    end else begin
      capt_valid <= in_fill && bus.memory_data_valid && !last_wr;
      if (in_fill && bus.memory_data_valid) begin
        capt_data <= bus.memory_data;
      end
    end
  end

  // Outputs depend only on registered state, so miss_detected cannot reach
  // them combinationally. Address and data read as zero when their strobe is
  // low.
  assign bus.fsm_busy         = in_fill;
  assign bus.mem_en           = req_en;
  assign bus.memory_address   = req_en ? (base | ADDR_W'(word_offset(issue_cnt[2:0])))
                                       : '0;
  assign bus.write_data_array = wr_en;
  assign bus.write_tag_array  = last_wr;
  assign bus.cache_wr_addr    = wr_en ? (base | ADDR_W'(word_offset(recv_cnt[2:0])))
                                      : '0;
  assign bus.cache_wr_data    = wr_en ? capt_data : '0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl. A behavioural memory returns one
// word per request after a fixed or irregular delay. A cycle-level reference
// model predicts every output, and scenario tasks add their own targeted
// comparisons.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl #(
    .WORDS_PER_BLOCK (8),
    .MEM_LATENCY     (4),
    .ADDR_W          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: fill status, block base, words requested, words
  // written, and the captured word waiting to be written.
  bit          m_busy;
  logic [15:0] m_base;
  int          m_req;
  int          m_wr;
  bit          m_capv;
  logic [15:0] m_capd;

  // Memory model: responses still to be returned, in request order.
  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_rsp_t;
  mem_rsp_t pend[$];
  bit rand_data;
  bit rand_gap;
  bit stray_mode;
  int last_due;

  // Advance one clock and compare DUT outputs against the model.
  task automatic tick();
    bit          was_last;
    bit          e_en, e_wr, e_tag;
    logic [15:0] e_addr, e_waddr, d;
    int          due;
    mem_rsp_t    r;
    // Model the edge, using the inputs the DUT is about to sample.
    if (rst) begin
      m_busy = 0; m_base = '0; m_req = 0; m_wr = 0; m_capv = 0; m_capd = '0;
    end else if (!m_busy) begin
      m_capv = 0;
      if (bus.miss_detected) begin
        m_busy = 1; m_base = bus.miss_address & 16'hFFF0; m_req = 0; m_wr = 0;
      end
    end else begin
      was_last = m_capv && (m_wr == 7);
      if (m_capv) m_wr++;
      if (m_req < 8) m_req++;
      m_capv = bus.memory_data_valid;
      m_capd = bus.memory_data;
      if (was_last) begin
        m_busy = 0;
        m_capv = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_en    = m_busy && (m_req < 8);
    e_wr    = m_busy && m_capv;
    e_tag   = e_wr && (m_wr == 7);
    e_addr  = m_base + 16'(2 * m_req);
    e_waddr = m_base + 16'(2 * m_wr);
    checks++;
    if (bus.fsm_busy !== m_busy) begin
      errors++;
      $display("FAIL model_busy cyc=%0d: got %b expected %b", cyc, bus.fsm_busy, m_busy);
    end
    checks++;
    if (bus.mem_en !== e_en) begin
      errors++;
      $display("FAIL model_mem_en cyc=%0d: got %b expected %b", cyc, bus.mem_en, e_en);
    end
    checks++;
    if (bus.write_data_array !== e_wr) begin
      errors++;
      $display("FAIL model_write cyc=%0d: got %b expected %b", cyc, bus.write_data_array, e_wr);
    end
    checks++;
    if (bus.write_tag_array !== e_tag) begin
      errors++;
      $display("FAIL model_tag cyc=%0d: got %b expected %b", cyc, bus.write_tag_array, e_tag);
    end
    if (e_en) begin
      checks++;
      if (bus.memory_address !== e_addr) begin
        errors++;
        $display("FAIL model_req_addr cyc=%0d: got %h expected %h", cyc, bus.memory_address, e_addr);
      end
    end
    if (e_wr) begin
      checks++;
      if (bus.cache_wr_addr !== e_waddr) begin
        errors++;
        $display("FAIL model_wr_addr cyc=%0d: got %h expected %h", cyc, bus.cache_wr_addr, e_waddr);
      end
      checks++;
      if (bus.cache_wr_data !== m_capd) begin
        errors++;
        $display("FAIL model_wr_data cyc=%0d: got %h expected %h", cyc, bus.cache_wr_data, m_capd);
      end
    end
    // Memory: accept this cycle's request, then drive any response due now.
    if (e_en && !rst) begin
      d   = rand_data ? 16'($urandom) : (16'hA000 + 16'(e_addr[3:1]));
      due = cyc + 4;
      if (rand_gap) begin
        if (due < last_due + 1) due = last_due + 1;
        due = due + int'($urandom_range(0, 3));
      end
      last_due = due;
      pend.push_back('{due: due, data: d});
    end
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    if (stray_mode) begin
      bus.memory_data_valid = 1'($urandom);
      bus.memory_data       = 16'($urandom);
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = r.data;
    end
  endtask

  // Present a miss for one cycle (the cycle the DUT samples it).
  task automatic start_miss(input logic [15:0] addr);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    tick();
    bus.miss_detected = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (pend.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.miss_detected = 1'b0; bus.miss_address = '0;
    bus.memory_data_valid = 1'b0; bus.memory_data = '0;
    tick();
    tick();
    checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.fsm_busy); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.memory_address); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", bus.write_data_array); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL reset_tag: got %b expected 0", bus.write_tag_array); end
    checks++; if (bus.cache_wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", bus.cache_wr_addr); end
    checks++; if (bus.cache_wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", bus.cache_wr_data); end
    rst = 1'b0;
    tick();
  endtask

  // Miss at 0812 with latency-4 memory; cycle-exact table of the fill.
  task automatic test_basic_fill();
    int          tags = 0;
    bit          e_en, e_wr, e_tag, e_busy;
    logic [15:0] e_addr, e_waddr, e_wdata;
    rand_data = 0; rand_gap = 0;
    start_miss(16'h0812);
    for (int r = 1; r <= 15; r++) begin
      e_en    = (r <= 8);
      e_wr    = (r >= 6) && (r <= 13);
      e_tag   = (r == 13);
      e_busy  = (r <= 13);
      e_addr  = 16'h0810 + 16'(2 * (r - 1));
      e_waddr = 16'h0810 + 16'(2 * (r - 6));
      e_wdata = 16'hA000 + 16'(r - 6);
      checks++; if (bus.fsm_busy !== e_busy) begin errors++; $display("FAIL basic_busy c%0d: got %b expected %b", r, bus.fsm_busy, e_busy); end
      checks++; if (bus.mem_en !== e_en) begin errors++; $display("FAIL basic_mem_en c%0d: got %b expected %b", r, bus.mem_en, e_en); end
      checks++; if (bus.write_data_array !== e_wr) begin errors++; $display("FAIL basic_write c%0d: got %b expected %b", r, bus.write_data_array, e_wr); end
      checks++; if (bus.write_tag_array !== e_tag) begin errors++; $display("FAIL basic_tag c%0d: got %b expected %b", r, bus.write_tag_array, e_tag); end
      if (e_en) begin
        checks++; if (bus.memory_address !== e_addr) begin errors++; $display("FAIL basic_req_addr c%0d: got %h expected %h", r, bus.memory_address, e_addr); end
      end
      if (e_wr) begin
        checks++; if (bus.cache_wr_addr !== e_waddr) begin errors++; $display("FAIL basic_wr_addr c%0d: got %h expected %h", r, bus.cache_wr_addr, e_waddr); end
        checks++; if (bus.cache_wr_data !== e_wdata) begin errors++; $display("FAIL basic_wr_data c%0d: got %h expected %h", r, bus.cache_wr_data, e_wdata); end
      end
      if (bus.write_tag_array === 1'b1) tags++;
      tick();
    end
    checks++; if (tags !== 1) begin errors++; $display("FAIL basic_tag_count: got %0d expected 1", tags); end
    drain();
  endtask

  // Miss at FFF6: block FFF0..FFFE, no wrap past the top of memory.
  task automatic test_block_top();
    logic [15:0] reqs[$];
    start_miss(16'hFFF6);
    for (int r = 1; r <= 20; r++) begin
      if (bus.mem_en === 1'b1) reqs.push_back(bus.memory_address);
      tick();
    end
    checks++; if (reqs.size() !== 8) begin errors++; $display("FAIL top_req_count: got %0d expected 8", reqs.size()); end
    if (reqs.size() == 8) begin
      checks++; if (reqs[0] !== 16'hFFF0) begin errors++; $display("FAIL top_first_req: got %h expected fff0", reqs[0]); end
      checks++; if (reqs[7] !== 16'hFFFE) begin errors++; $display("FAIL top_last_req: got %h expected fffe", reqs[7]); end
      foreach (reqs[i]) begin
        checks++; if (reqs[i][15:4] !== 12'hFFF) begin errors++; $display("FAIL top_wrap req%0d: got %h expected fff0..fffe", i, reqs[i]); end
      end
    end
    drain();
  endtask

  // miss_detected held through a fill; the next miss (1230) waits for idle.
  task automatic test_back_to_back();
    logic [15:0] a1;
    int rel = 1, last1 = -1, first2 = -1, guard = 0;
    a1 = {4'h5, 12'($urandom)};
    bus.miss_detected = 1'b1;
    bus.miss_address  = a1;
    tick();
    while (m_busy && guard < 40) begin
      if (bus.mem_en === 1'b1 && bus.memory_address[15:4] == a1[15:4]) last1 = rel;
      tick(); rel++; guard++;
    end
    checks++; if (rel !== 14) begin errors++; $display("FAIL b2b_busy_fall: got cycle %0d expected 14", rel); end
    bus.miss_address = 16'h1230;
    tick(); rel++;
    bus.miss_detected = 1'b0;
    guard = 0;
    while (m_busy && guard < 40) begin
      if (bus.mem_en === 1'b1 && bus.memory_address[15:4] == 12'h123 && first2 < 0) first2 = rel;
      tick(); rel++; guard++;
    end
    if (guard >= 40) begin errors++; $display("FAIL b2b_timeout: got no idle expected idle within 40 cycles"); end
    checks++; if (last1 !== 8) begin errors++; $display("FAIL b2b_last_req1: got cycle %0d expected 8", last1); end
    checks++; if (first2 !== 15) begin errors++; $display("FAIL b2b_first_req2: got cycle %0d expected 15", first2); end
    drain();
  endtask

  // Irregular return gaps and random data; tag only on the eighth write.
  task automatic test_irregular();
    int writes, tags, tag_at, guard;
    rand_data = 1; rand_gap = 1; last_due = 0;
    for (int f = 0; f < 4; f++) begin
      writes = 0; tags = 0; tag_at = -1; guard = 0;
      start_miss(16'($urandom));
      while (m_busy && guard < 120) begin
        if (bus.write_data_array === 1'b1) writes++;
        if (bus.write_tag_array === 1'b1) begin tags++; tag_at = writes; end
        tick(); guard++;
      end
      if (guard >= 120) begin errors++; $display("FAIL irr_timeout f%0d: got busy expected idle within 120 cycles", f); end
      checks++; if (writes !== 8) begin errors++; $display("FAIL irr_writes f%0d: got %0d expected 8", f, writes); end
      checks++; if (tags !== 1) begin errors++; $display("FAIL irr_tags f%0d: got %0d expected 1", f, tags); end
      checks++; if (tag_at !== 8) begin errors++; $display("FAIL irr_tag_pos f%0d: got write %0d expected 8", f, tag_at); end
      drain();
    end
    rand_data = 0; rand_gap = 0;
  endtask

  // Reset in cycle 7 of a fill; late returns must not write.
  task automatic test_reset_mid_fill();
    int writes = 0, tags = 0;
    start_miss(16'($urandom));
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.fsm_busy); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL rstmid_mem_addr: got %h expected 0", bus.memory_address); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b expected 0", bus.write_data_array); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL rstmid_tag: got %b expected 0", bus.write_tag_array); end
    checks++; if (bus.cache_wr_addr !== 16'h0) begin errors++; $display("FAIL rstmid_wr_addr: got %h expected 0", bus.cache_wr_addr); end
    checks++; if (bus.cache_wr_data !== 16'h0) begin errors++; $display("FAIL rstmid_wr_data: got %h expected 0", bus.cache_wr_data); end
    repeat (16) begin
      tick();
      if (bus.write_data_array !== 1'b0) writes++;
      if (bus.write_tag_array !== 1'b0) tags++;
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL rstmid_stray_writes: got %0d expected 0", writes); end
    checks++; if (tags !== 0) begin errors++; $display("FAIL rstmid_stray_tags: got %0d expected 0", tags); end
    drain();
  endtask

  // memory_data_valid pulses while idle produce no cache activity.
  task automatic test_idle_valid();
    int writes = 0, tags = 0;
    stray_mode = 1;
    repeat (12) begin
      tick();
      if (bus.write_data_array !== 1'b0) writes++;
      if (bus.write_tag_array !== 1'b0) tags++;
    end
    stray_mode = 0;
    tick();
    checks++; if (writes !== 0) begin errors++; $display("FAIL idle_writes: got %0d expected 0", writes); end
    checks++; if (tags !== 0) begin errors++; $display("FAIL idle_tags: got %0d expected 0", tags); end
  endtask

  initial begin
    rand_data = 0; rand_gap = 0; stray_mode = 0; last_due = 0;
    m_busy = 0; m_base = '0; m_req = 0; m_wr = 0; m_capv = 0; m_capd = '0;
    test_reset();
    test_basic_fill();
    test_block_top();
    test_back_to_back();
    test_irregular();
    test_reset_mid_fill();
    test_idle_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that sits on the memory side of the instruction/data caches. When a cache reports a miss, it fetches the full 16-byte block from the multi-cycle main memory one word at a time and writes each returned word into the cache data array. It pulses the tag-array write when the last word lands, then releases the pipeline stall.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes)
- MEM_LATENCY, 4, cycles from memory request to memory_data_valid (informational; the block counts returned valids, not cycles)
- ADDR_W, 16, byte address width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- miss_detected  in  1  cache miss indication, level, sampled only in IDLE
- miss_address  in  16  byte address of the missing access
- memory_data_valid  in  1  memory returns one word this cycle
- memory_data  in  16  returned word, valid with memory_data_valid
- fsm_busy  out  1  fill in progress; used to stall the pipeline
- mem_en  out  1  read request to memory this cycle
- memory_address  out  16  byte address of the current memory request
- write_data_array  out  1  write cache_wr_data into data array this cycle
- write_tag_array  out  1  write tag/valid for the block this cycle (single pulse)
- cache_wr_addr  out  16  byte address of the word being written into the cache
- cache_wr_data  out  16  word being written into the cache (registered copy of memory_data)

## Operation
- States: IDLE, FILL.
- IDLE: fsm_busy=0, mem_en=0. If miss_detected=1, latch base = miss_address & 16'hFFF0, clear issue_cnt and recv_cnt (4-bit each), go to FILL.
- FILL, request side: while issue_cnt < 8, mem_en=1 and memory_address = base + {issue_cnt[2:0],1'b0}; issue_cnt increments each cycle. issue_cnt holds at 8. No further requests after 8.
- FILL, return side: on each memory_data_valid, the word is captured and written to the cache the next cycle. write_data_array=1, cache_wr_addr = base + {recv_cnt[2:0],1'b0}, cache_wr_data = captured word. recv_cnt then increments.
- On the write of the 8th word (recv_cnt==7 at write), write_tag_array=1 in the same cycle. The FSM then returns to IDLE.
- miss_detected while in FILL is ignored. memory_data_valid in IDLE is ignored and produces no write.
- Offset arithmetic is 4-bit with no carry into base. The block never crosses a 16-byte boundary. Base 16'hFFF0 yields requests FFF0..FFFE.
- Reset (any state, including mid-fill): next edge forces IDLE and clears the counters and base to 0. All outputs drop to 0 and any in-flight words are discarded.

## Timing
- Reset values: fsm_busy=0, mem_en=0, memory_address=0, write_data_array=0, write_tag_array=0, cache_wr_addr=0, cache_wr_data=0.
- Cycle 0: IDLE samples miss_detected=1.
- Cycles 1–8: fsm_busy=1 and mem_en=1, addresses base+0 … base+14.
- With MEM_LATENCY=4, valids arrive in cycles 5–12 and cache writes occur in cycles 6–13.
- Cycle 13: write_tag_array=1 together with the last write_data_array. fsm_busy is still 1 in cycle 13 and 0 in cycle 14.
- A new miss can be accepted in cycle 14. Minimum miss-to-miss spacing is 14 cycles at latency 4.
- fsm_busy is registered and high for every cycle in FILL. Outputs are combinational from state, counters and registered capture only. There is no combinational path from miss_detected to any output.

## Structure
- Shared package cache_pkg: BLOCK_BYTES=16, WORDS_PER_BLOCK=8, OFFSET_MASK=16'h000F, and the fill state encoding (IDLE, FILL). The caches use the same constants for index/tag split.
- One sub-module, fill_counter: 4-bit counter with synchronous clear, enable, and saturate-at-8. Instantiated twice (issue_cnt, recv_cnt).
- Top module holds the FSM, base register and data capture register.

## Test plan
- Reset then miss at 16'h0812 with a latency-4 memory model returning data 16'hA000+i. Expected: requests to 0810, 0812 … 081E in cycles 1–8. Cache writes 0810←A000 … 081E←A007. One write_tag_array pulse in cycle 13. fsm_busy low in cycle 14.
- Miss at 16'hFFF6. Expected: base FFF0, last request FFFE, no wrap to 0000.
- miss_detected held high throughout the fill and again at 16'h1230. Expected: second fill starts only after fsm_busy falls, with no overlap of requests between the two fills.
- Memory model with irregular valids (gaps of 0–3 cycles). Expected: writes follow valid order and addresses stay sequential. Tag pulse occurs on the 8th write only.
- rst asserted in cycle 7 of a fill. Expected: all outputs 0 next cycle and state IDLE. Later stray memory_data_valid pulses cause no writes.
- memory_data_valid pulsed while IDLE. Expected: no write_data_array or write_tag_array activity.
